// File: rtl/i2s_rx.sv
// i2s_rx: Philips-mode I2S slave receiver.
// It deserialises MSB-first channel words into a small valid/ready FIFO.
// Overflow and framing errors are reported as sticky flags plus an interrupt.
module i2s_rx #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic                i2s_bclk_i,
    input  logic                i2s_lrclk_i,
    input  logic                i2s_sdata_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_chan_o,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output logic                overflow_o,
    output logic                frame_err_o,
    output logic                irq_o
);
    localparam int CW = $clog2(SAMPLE_W + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(SAMPLE_W);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    logic [2:0]          bclk_s;
    logic [1:0]          lr_s;
    logic [1:0]          sd_s;
    logic                rise;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_n;
    logic [SAMPLE_W-1:0] shift;
    logic [SAMPLE_W-1:0] shift_n;
    logic                cur_chan;
    logic                lr_prev;
    logic                armed;
    logic                cap;
    logic                complete;
    logic                lr_chg;
    logic                ferr_evt;
    logic                ovf_evt;
    logic                full;
    logic                push;
    logic                pop;
    logic [SAMPLE_W:0]   mem [FIFO_DEPTH];
    logic [AW:0]         wp;
    logic [AW:0]         rp;
    logic                ovf_q;
    logic                ferr_q;

    // Synchronise the bus lines and register a one-cycle pulse per bclk rise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bclk_s <= '0;
            lr_s   <= '0;
            sd_s   <= '0;
            rise   <= 1'b0;
        end else begin
            bclk_s <= {bclk_s[1:0], i2s_bclk_i};
            lr_s   <= {lr_s[0], i2s_lrclk_i};
            sd_s   <= {sd_s[0], i2s_sdata_i};
            rise   <= bclk_s[1] & ~bclk_s[2];
        end
    end

    // Per-rise capture first, then word-select edge handling, then FIFO accept
    always_comb begin
        cap      = rise && enable_i && armed && (cnt < FULL_CNT);
        cnt_n    = cap ? cnt + 1'b1 : cnt;
        shift_n  = cap ? {shift[SAMPLE_W-2:0], sd_s[1]} : shift;
        complete = cap && (cnt_n == FULL_CNT);
        lr_chg   = rise && enable_i && (lr_s[1] != lr_prev);
        ferr_evt = lr_chg && armed && (cnt_n < FULL_CNT);
        full     = (wp - rp) == DEPTH;
        pop      = sample_valid_o && sample_ready_i;
        push     = complete && (!full || pop);
        ovf_evt  = complete && full && !pop;
    end

    // Deserialiser state; a word-select edge restarts the count for the new channel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= '0;
            shift    <= '0;
            cur_chan <= 1'b0;
            lr_prev  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            shift <= shift_n;
            cnt   <= (!enable_i || lr_chg) ? '0 : cnt_n;
            if (rise)
                lr_prev <= lr_s[1];
            if (!enable_i)
                armed <= 1'b0;
            else if (lr_chg) begin
                armed    <= 1'b1;
                cur_chan <= lr_s[1];
            end
        end
    end

    // FIFO storage; the completing word is written with the channel it was captured under
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wp[AW-1:0]] <= {cur_chan, shift_n};
    end

    // FIFO pointers; disabling the receiver empties the queue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp <= '0;
            rp <= '0;
        end else if (!enable_i) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
        end
    end

    // Sticky error flags; a new event in the same cycle as clear keeps the flag set
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_evt | (ovf_q & ~clear_i);
            ferr_q <= ferr_evt | (ferr_q & ~clear_i);
        end
    end

    assign sample_valid_o            = wp != rp;
    assign {sample_chan_o, sample_o} = sample_valid_o ? mem[rp[AW-1:0]] : '0;
    assign overflow_o                = ovf_q;
    assign frame_err_o               = ferr_q;
    assign irq_o                     = ovf_q | ferr_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: vector table, hand-built corner sequences and random word streams for i2s_rx.
module tb_i2s_rx;
    localparam int W = 16;
    localparam int D = 4;

    typedef struct {
        logic         chan;
        logic [W-1:0] data;
        int           nbits;
        int           pad;
    } word_t;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           lbits;
        int           pad;
        logic [W:0]   e0;
        logic [W:0]   e1;
        int           nexp;
        logic         eferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic sdata = 1'b0;
    logic ready = 1'b0;
    logic [W-1:0] sample;
    logic chan, valid, ovf, ferr, irq;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;
    logic [W:0] got[$];
    logic [W:0] exp_q[$];
    word_t words[$];
    vec_t vt[5];

    always #5 clk = ~clk;

    i2s_rx #(.SAMPLE_W(W), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
        .i2s_bclk_i(bclk), .i2s_lrclk_i(lrclk), .i2s_sdata_i(sdata),
        .sample_o(sample), .sample_chan_o(chan), .sample_valid_o(valid),
        .sample_ready_i(ready), .overflow_o(ovf), .frame_err_o(ferr), .irq_o(irq)
    );

    // consumer: 0 = always ready, 1 = stalled, 2 = random
    always @(posedge clk) begin
        #1;
        ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) if (valid && ready) got.push_back({chan, sample});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one BCLK period: lrclk/sdata change while bclk is low, sampled at the rise
    task automatic slot(input logic lr, input logic sd);
        bclk = 1'b0;
        lrclk = lr;
        sdata = sd;
        cyc(8);
        bclk = 1'b1;
        cyc(8);
    endtask

    // serialises the word list; each bit goes out one BCLK after its word-select period starts
    task automatic send_words();
        logic prev_sd;
        prev_sd = 1'b0;
        foreach (words[i]) begin
            for (int j = 0; j < words[i].nbits + words[i].pad; j++) begin
                slot(words[i].chan, prev_sd);
                prev_sd = (j < words[i].nbits) ? words[i].data[W-1-j] : 1'b1;
            end
        end
        slot(~words[words.size()-1].chan, prev_sd);
    endtask

    // disarm, park lrclk opposite to the next first channel, then re-enable
    task automatic resync(input logic first_chan);
        enable = 1'b0;
        cyc(2);
        slot(~first_chan, 1'b0);
        enable = 1'b1;
        cyc(2);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    // reference: a word emerges only if all SAMPLE_W bits arrived inside its period
    task automatic model(output logic eferr);
        exp_q.delete();
        eferr = 1'b0;
        foreach (words[i]) begin
            if (words[i].nbits == W)
                exp_q.push_back({words[i].chan, words[i].data});
            else
                eferr = 1'b1;
        end
    endtask

    task automatic rand_words(input int n, input logic c0, input bit allow_short);
        word_t w;
        words.delete();
        for (int i = 0; i < n; i++) begin
            w.chan = c0 ^ 1'(i);
            w.data = W'($urandom);
            if (allow_short && $urandom_range(0, 3) == 0) begin
                w.nbits = $urandom_range(1, W - 1);
                w.pad = 0;
            end else begin
                w.nbits = W;
                w.pad = $urandom_range(0, 3);
            end
            words.push_back(w);
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s word%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " sample"}, sample, 0);
        check({tag, " chan"}, chan, 0);
        check({tag, " valid"}, valid, 0);
        check({tag, " ovf"}, ovf, 0);
        check({tag, " ferr"}, ferr, 0);
        check({tag, " irq"}, irq, 0);
    endtask

    initial begin
        logic eferr;
        vt[0] = '{16'hA5C3, 16'h1234, 16, 0, 17'h0A5C3, 17'h11234, 2, 1'b0};
        vt[1] = '{16'hA5C3, 16'h1234, 16, 4, 17'h0A5C3, 17'h11234, 2, 1'b0};
        vt[2] = '{16'hBEEF, 16'h1234, 10, 0, 17'h11234, 17'h00000, 1, 1'b1};
        vt[3] = '{16'hFFFF, 16'h0001, 16, 1, 17'h0FFFF, 17'h10001, 2, 1'b0};
        vt[4] = '{16'h8000, 16'h7FFF, 16, 0, 17'h08000, 17'h17FFF, 2, 1'b0};

        cyc(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        cyc(2);

        // table-driven L/R frames
        ready_mode = 0;
        for (int v = 0; v < 5; v++) begin
            pulse_clear();
            resync(1'b0);
            got.delete();
            words.delete();
            words.push_back('{1'b0, vt[v].l, vt[v].lbits, (vt[v].lbits == W) ? vt[v].pad : 0});
            words.push_back('{1'b1, vt[v].r, W, vt[v].pad});
            send_words();
            cyc(10);
            exp_q.delete();
            exp_q.push_back(vt[v].e0);
            if (vt[v].nexp > 1)
                exp_q.push_back(vt[v].e1);
            compare_stream($sformatf("vec%0d", v));
            check($sformatf("vec%0d ferr", v), ferr, vt[v].eferr);
            check($sformatf("vec%0d irq", v), irq, vt[v].eferr);
            check($sformatf("vec%0d ovf", v), ovf, 0);
            if (vt[v].eferr) begin
                pulse_clear();
                check($sformatf("vec%0d ferr cleared", v), ferr, 0);
                check($sformatf("vec%0d irq cleared", v), irq, 0);
            end
        end

        // overflow: 6 words into a stalled 4-entry FIFO
        ready_mode = 1;
        pulse_clear();
        resync(1'b0);
        got.delete();
        rand_words(6, 1'b0, 1'b0);
        model(eferr);
        while (exp_q.size() > D)
            void'(exp_q.pop_back());
        send_words();
        cyc(4);
        check("ovf flag", ovf, 1);
        check("ovf irq", irq, 1);
        check("ovf valid", valid, 1);
        check("ovf head", {chan, sample}, exp_q[0]);
        ready_mode = 0;
        cyc(12);
        compare_stream("ovf drain");
        pulse_clear();
        check("ovf cleared", ovf, 0);

        // stream joined mid-word: nothing until the first word-select edge
        resync(1'b0);
        got.delete();
        for (int i = 0; i < 7; i++)
            slot(1'b1, 1'($urandom_range(0, 1)));
        check("midstart valid", valid, 0);
        check("midstart ferr", ferr, 0);
        rand_words(2, 1'b0, 1'b0);
        model(eferr);
        send_words();
        cyc(10);
        compare_stream("midstart");
        check("midstart ferr after", ferr, 0);

        // enable dropped with two words buffered, then clean restart
        ready_mode = 1;
        resync(1'b0);
        rand_words(2, 1'b0, 1'b0);
        send_words();
        for (int i = 0; i < 5; i++)
            slot(1'b0, 1'($urandom_range(0, 1)));
        check("endrop buffered", valid, 1);
        enable = 1'b0;
        cyc(1);
        check("endrop valid", valid, 0);
        cyc(3);
        enable = 1'b1;
        for (int i = 0; i < 6; i++)
            slot(1'b0, 1'($urandom_range(0, 1)));
        got.delete();
        rand_words(1, 1'b1, 1'b0);
        model(eferr);
        send_words();
        ready_mode = 0;
        cyc(10);
        compare_stream("reenable");
        check("reenable ferr", ferr, 0);

        // reset mid-word with a flag set and data buffered
        ready_mode = 1;
        resync(1'b0);
        words.delete();
        words.push_back('{1'b0, 16'h1357, 5, 0});
        words.push_back('{1'b1, 16'h2468, W, 0});
        send_words();
        for (int i = 0; i < 4; i++)
            slot(1'b0, 1'b1);
        check("prereset ferr", ferr, 1);
        check("prereset valid", valid, 1);
        #2;
        rst_n = 1'b0;
        #2;
        check_idle_outputs("midreset");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // random word streams with random short words and consumer stalls
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            logic c0;
            c0 = 1'($urandom_range(0, 1));
            pulse_clear();
            resync(c0);
            got.delete();
            rand_words(10, c0, 1'b1);
            model(eferr);
            send_words();
            cyc(40);
            compare_stream($sformatf("rand%0d", r));
            check($sformatf("rand%0d ferr", r), ferr, eferr);
            check($sformatf("rand%0d ovf", r), ovf, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
